hybrid_pwm_sd_mc: RTL and testbench



---
 rtl/hybrid_dac_pkg.sv | 24 ++
 rtl/hybrid_pwm_sd_scaler.sv | 25 ++
 rtl/hybrid_pwm_sd_mc.sv | 198 +++++++++++++++++++
 tb/tb_hybrid_pwm_sd_mc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_dac_pkg.sv
// Shared types and constant helpers for the hybrid PWM / sigma-delta DAC.
package hybrid_dac_pkg;

  // Anti-pop sequencer states
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } dac_state_e;

  // Full-scale input maps to (2^p - 2) PWM steps, expressed in DW-bit units
  function automatic logic [63:0] scale_const(input int dw, input int p);
    logic [63:0] k;
    k = (64'd1 << p) - 64'd2;
    return k << (dw - p);
  endfunction

  // Rounding offset of the scaled product: one PWM step in the product domain
  function automatic logic [63:0] offset_const(input int dw, input int p);
    return 64'd1 << (2 * dw - p);
  endfunction

endpackage

// File: rtl/hybrid_pwm_sd_scaler.sv
// Shared combinational scale-and-add: sum = ((x*K + OFF) >> DW) + frac + dith.
// The result cannot wrap with dith == 0: the scaled value tops out below
// (2^P - 1) * 2^(DW-P) and frac is strictly below 2^(DW-P).
module hybrid_pwm_sd_scaler
  import hybrid_dac_pkg::*;
#(
  parameter int DW       = 16,
  parameter int PWM_BITS = 5
) (
  input  logic [DW-1:0]          x,
  input  logic [DW-PWM_BITS-1:0] frac,
  input  logic [DW-1:0]          dith,
  output logic [DW-1:0]          sum
);

  localparam logic [2*DW-1:0] SCALE  = (2*DW)'(scale_const(DW, PWM_BITS));
  localparam logic [2*DW-1:0] OFFSET = (2*DW)'(offset_const(DW, PWM_BITS));

  logic [DW-1:0] s;

  // Full-precision product, upper half kept
  assign s   = DW'(({{DW{1'b0}}, x} * SCALE + OFFSET) >> DW);
  assign sum = s + {{PWM_BITS{1'b0}}, frac} + dith;

endmodule

// File: rtl/hybrid_pwm_sd_mc.sv
// Multi-channel hybrid PWM / first-order sigma-delta audio DAC with an
// anti-pop ramp sequencer. One scaler is shared round-robin: channel ch
// is refreshed at each PWM period end, so each channel updates once every
// CHANNELS periods.
// Optional dither: define HYBRID_PWM_SD_DITHER_EN to add LFSR noise below
// the threshold split while running.
module hybrid_pwm_sd_mc
  import hybrid_dac_pkg::*;
#(
  parameter int                   CHANNELS   = 2,
  parameter int                   DW         = 16,
  parameter int                   PWM_BITS   = 5,
  parameter int                   DUMP_BITS  = 8,
  parameter int                   RAMP_BITS  = 14,
  parameter logic [RAMP_BITS-1:0] RAMP_START = 14'h3E00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   terminate,
  input  logic [CHANNELS*DW-1:0] d,
  output logic [CHANNELS-1:0]    q,
  output logic                   running,
  output logic                   terminated
);

  localparam int FW   = DW - PWM_BITS;
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RMSB = RAMP_BITS - 1;

  // Accumulator reset value has its top 4 bits set; only the fraction is
  // stored, the integer part of the last sum lives in thr.
  localparam logic [DW-1:0]       ACC_RST   = {4'hF, {(DW-4){1'b0}}};
  localparam logic [FW-1:0]       FRAC_RST  = ACC_RST[FW-1:0];
  localparam logic [FW-1:0]       FRAC_HALF = {1'b1, {(FW-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] THR_RST   = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0]  cnt;
  logic [PWM_BITS-1:0]  thr      [CHANNELS];
  logic [FW-1:0]        acc_frac [CHANNELS];
  logic [CW-1:0]        ch;
  logic [DUMP_BITS-1:0] dump_cnt;
  logic                 dump;
  logic                 period_end;
  logic [RAMP_BITS-1:0] ramp, ramp_n;
  dac_state_e           state, state_n;

  logic [DW-1:0] ramp_x;
  logic [DW-1:0] d_sel;
  logic [DW-1:0] x_sel;
  logic [FW-1:0] frac_sel;
  logic [DW-1:0] dith;
  logic [DW-1:0] sum;

  assign period_end = (cnt == '1);

  // Ramp value aligned to the top of the sample word
  always_comb begin
    ramp_x = '0;
    ramp_x[DW-1 -: RAMP_BITS] = ramp;
  end

  assign d_sel    = d[ch*DW +: DW];
  assign x_sel    = (state == ST_RUN) ? d_sel : ramp_x;
  assign frac_sel = acc_frac[ch];

`ifdef HYBRID_PWM_SD_DITHER_EN
  logic [15:0] lfsr;

  // Galois LFSR stepped once per PWM period
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (period_end) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end
  end

  // Dither only while playing real samples
  always_comb begin
    dith = '0;
    if (state == ST_RUN) dith[FW-3:0] = lfsr[FW-3:0];
  end
`else
  assign dith = '0;
`endif

  hybrid_pwm_sd_scaler #(
    .DW       (DW),
    .PWM_BITS (PWM_BITS)
  ) u_scaler (
    .x    (x_sel),
    .frac (frac_sel),
    .dith (dith),
    .sum  (sum)
  );

  // PWM counter and outputs; the period-end set wins over the threshold clear
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '1;
      q   <= '1;
    end else begin
      cnt <= cnt + 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (period_end)       q[c] <= 1'b1;
        else if (cnt == thr[c]) q[c] <= 1'b0;
      end
    end
  end

  // Round-robin sigma-delta update; dump recentres every fraction
  always_ff @(posedge clk) begin
    if (reset) begin
      ch <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        thr[c]      <= THR_RST;
        acc_frac[c] <= FRAC_RST;
      end
    end else begin
      if (period_end) begin
        thr[ch]      <= sum[DW-1 -: PWM_BITS];
        acc_frac[ch] <= sum[FW-1:0];
        ch           <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
      end
      if (dump) begin
        for (int c = 0; c < CHANNELS; c++) acc_frac[c] <= FRAC_HALF;
      end
    end
  end

  // Dump divider: one-cycle pulse just after the period end that saw zero
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_cnt <= '0;
      dump     <= 1'b0;
    end else begin
      dump <= period_end && (dump_cnt == '0);
      if (period_end) dump_cnt <= dump_cnt + 1'b1;
    end
  end

  // Anti-pop sequencer next state and ramp
  always_comb begin
    state_n = state;
    ramp_n  = ramp;
    case (state)
      ST_INIT: begin
        if (dump) begin
          if (!ramp[RMSB]) begin
            state_n = ST_RUN;
          end else begin
            ramp_n = ramp - 1'b1;
            if (!ramp_n[RMSB]) state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (terminate) begin
          ramp_n  = ramp + 1'b1;
          state_n = ST_TERM;
        end
      end
      ST_TERM: begin
        if (dump) begin
          if (!terminate) begin
            state_n = ST_INIT;
          end else if (ramp == '1) begin
            state_n = ST_DONE;
          end else begin
            ramp_n = ramp + 1'b1;
            if (ramp_n == '1) state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        ramp_n = '1;
        if (dump && !terminate) state_n = ST_INIT;
      end
      default: state_n = ST_INIT;
    endcase
  end

  // Sequencer registers and registered status decodes
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      ramp       <= RAMP_START;
      running    <= 1'b0;
      terminated <= 1'b0;
    end else begin
      state      <= state_n;
      ramp       <= ramp_n;
      running    <= (state_n == ST_RUN);
      terminated <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_hybrid_pwm_sd_mc.sv
// Directed bench for hybrid_pwm_sd_mc: 4 channels, 5-bit PWM, dump every
// 2 periods and a 6-bit ramp starting at 0x24 (five dumps to reach RUN).
module tb_hybrid_pwm_sd_mc;
  import hybrid_dac_pkg::*;

  localparam int                CH = 4;
  localparam int                DW = 16;
  localparam int                PB = 5;
  localparam int                DB = 1;
  localparam int                RB = 6;
  localparam logic [RB-1:0]     RS = 6'h24;
  localparam int                PER = 1 << PB;

  logic             clk;
  logic             reset;
  logic             terminate;
  logic [CH*DW-1:0] d;
  logic [CH-1:0]    q;
  logic             running;
  logic             terminated;

  int checks = 0;
  int passed = 0;
  int duty [CH];
  logic [1:0] exp_q[$];

  typedef struct {
    logic [15:0] d;
    int          lo;
    int          hi;
  } vec_t;

  vec_t vecs [6];

  hybrid_pwm_sd_mc #(
    .CHANNELS   (CH),
    .DW         (DW),
    .PWM_BITS   (PB),
    .DUMP_BITS  (DB),
    .RAMP_BITS  (RB),
    .RAMP_START (RS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .terminate  (terminate),
    .d          (d),
    .q          (q),
    .running    (running),
    .terminated (terminated)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    check_rng(name, act, exp, exp);
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int c = 0; c < CH; c++) d[c*DW +: DW] = v;
  endtask

  // what: 0 = running, 1 = terminated, 2 = state INIT; counts dumps on the way
  task automatic run_until(input int what, input int budget, output int dumps, output bit ok);
    dumps = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((what == 0 && running) || (what == 1 && terminated) ||
          (what == 2 && dut.state == ST_INIT)) begin
        ok = 1'b1;
        break;
      end
      if (dut.dump) dumps++;
    end
  endtask

  task automatic wait_dumps(input int n, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.dump) begin
        seen++;
        if (seen == n) begin
          @(negedge clk);
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic align_period();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (dut.cnt == 0) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("align_period", int'(found), 1);
  endtask

  // High clocks per channel over one PWM period starting at counter 0
  task automatic measure_duty();
    align_period();
    for (int c = 0; c < CH; c++) duty[c] = 0;
    for (int k = 0; k < PER; k++) begin
      if (k > 0) @(negedge clk);
      for (int c = 0; c < CH; c++) if (q[c]) duty[c]++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_q"}, int'(q), 15);
    check_eq({tag, "_running"}, int'(running), 0);
    check_eq({tag, "_terminated"}, int'(terminated), 0);
    check_eq({tag, "_state"}, int'(dut.state), int'(ST_INIT));
    check_eq({tag, "_ramp"}, int'(dut.ramp), int'(RS));
    check_eq({tag, "_cnt"}, int'(dut.cnt), PER - 1);
    for (int c = 0; c < CH; c++)
      check_eq($sformatf("%s_thr%0d", tag, c), int'(dut.thr[c]), PER - 2);
  endtask

  initial begin
    int n;
    bit ok;
    int first;
    int idx;
    int nchg;
    logic [PB-1:0] snap [CH];
    int lo_o [CH];
    int hi_o [CH];

    vecs[0] = '{16'h8000, 16, 16};
    vecs[1] = '{16'h0000, 1, 1};
    vecs[2] = '{16'hFFFF, 30, 31};
    vecs[3] = '{16'h4000, 8, 9};
    vecs[4] = '{16'hC000, 23, 24};
    vecs[5] = '{16'h0000, 1, 1};

    reset = 1'b1;
    terminate = 1'b0;
    set_all(16'h8000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("rst");

    // Power-on ramp: five dumps take 0x24 down to 0x1F
    run_until(0, 2000, n, ok);
    check_eq("init_reach_run", int'(ok), 1);
    check_eq("init_dumps", n, 5);
    check_eq("init_ramp", int'(dut.ramp), 'h1F);

    // Uniform samples: threshold and duty per channel
    for (int v = 0; v < 6; v++) begin
      set_all(vecs[v].d);
      repeat (6 * PER) @(negedge clk);
      for (int c = 0; c < CH; c++)
        check_rng($sformatf("thr_v%0d_c%0d", v, c), int'(dut.thr[c]), vecs[v].lo, vecs[v].hi);
      measure_duty();
      for (int c = 0; c < CH; c++)
        check_rng($sformatf("duty_v%0d_c%0d", v, c), duty[c], vecs[v].lo + 1,
                  (vecs[v].hi == PER - 1) ? PER : vecs[v].hi + 1);
      check_eq($sformatf("running_v%0d", v), int'(running), 1);
    end

    // Distinct samples: exactly one channel refreshes per period, in order
    align_period();
    d[0*DW +: DW] = 16'h8000; lo_o[0] = 16; hi_o[0] = 16;
    d[1*DW +: DW] = 16'h2000; lo_o[1] = 4;  hi_o[1] = 5;
    d[2*DW +: DW] = 16'hFFFF; lo_o[2] = 30; hi_o[2] = 31;
    d[3*DW +: DW] = 16'h4000; lo_o[3] = 8;  hi_o[3] = 9;
    for (int c = 0; c < CH; c++) snap[c] = dut.thr[c];
    first = -1;
    for (int p = 0; p < CH; p++) begin
      repeat (PER) @(negedge clk);
      nchg = 0;
      idx = -1;
      for (int c = 0; c < CH; c++) begin
        if (dut.thr[c] != snap[c]) begin
          nchg++;
          idx = c;
        end
      end
      check_eq($sformatf("order_single_p%0d", p), nchg, 1);
      if (p == 0) begin
        first = idx;
        for (int k = 1; k < CH; k++) exp_q.push_back(2'((first + k) % CH));
      end else begin
        check_eq($sformatf("order_idx_p%0d", p), idx, int'(exp_q.pop_front()));
      end
      if (idx >= 0) begin
        check_rng($sformatf("order_thr_p%0d", p), int'(dut.thr[idx]), lo_o[idx], hi_o[idx]);
        for (int c = 0; c < CH; c++) snap[c] = dut.thr[c];
      end
    end

    // Terminate: full ramp to all-ones, hold, then descend back to RUN
    @(negedge clk);
    terminate = 1'b1;
    @(negedge clk);
    check_eq("term_state", int'(dut.state), int'(ST_TERM));
    check_eq("term_ramp", int'(dut.ramp), 'h20);
    check_eq("term_running", int'(running), 0);
    run_until(1, 5000, n, ok);
    check_eq("term_reach_done", int'(ok), 1);
    check_eq("term_dumps", n, 31);
    check_eq("done_ramp", int'(dut.ramp), 'h3F);
    check_eq("done_state", int'(dut.state), int'(ST_DONE));
    wait_dumps(4, 1000, ok);
    check_eq("done_hold_bound", int'(ok), 1);
    check_eq("done_hold_ramp", int'(dut.ramp), 'h3F);
    check_eq("done_hold_terminated", int'(terminated), 1);
    terminate = 1'b0;
    run_until(2, 500, n, ok);
    check_eq("release_reach_init", int'(ok), 1);
    check_eq("release_dumps", n, 1);
    check_eq("release_terminated", int'(terminated), 0);
    run_until(0, 5000, n, ok);
    check_eq("descend_reach_run", int'(ok), 1);
    check_eq("descend_dumps", n, 32);
    check_eq("descend_ramp", int'(dut.ramp), 'h1F);

    // Reversal mid-ramp: back to INIT, then four dumps to RUN
    terminate = 1'b1;
    @(negedge clk);
    check_eq("rev_state", int'(dut.state), int'(ST_TERM));
    wait_dumps(3, 1000, ok);
    check_eq("rev_wait_bound", int'(ok), 1);
    check_eq("rev_ramp", int'(dut.ramp), 'h23);
    terminate = 1'b0;
    run_until(2, 500, n, ok);
    check_eq("rev_reach_init", int'(ok), 1);
    check_eq("rev_init_dumps", n, 1);
    check_eq("rev_init_ramp", int'(dut.ramp), 'h23);
    run_until(0, 2000, n, ok);
    check_eq("rev_reach_run", int'(ok), 1);
    check_eq("rev_run_dumps", n, 4);

    // Reset in the middle of a terminate ramp
    terminate = 1'b1;
    @(negedge clk);
    check_eq("midterm_state", int'(dut.state), int'(ST_TERM));
    wait_dumps(2, 1000, ok);
    check_eq("midterm_wait_bound", int'(ok), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b0;
    terminate = 1'b0;
    run_until(0, 2000, n, ok);
    check_eq("rerun_reach", int'(ok), 1);
    check_eq("rerun_dumps", n, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
